alu_issue_ctrl: RTL and testbench

- Initiator side of the datapath ALU interface.
- Accepts one RV64 integer ALU instruction (OP / OP-IMM) plus register operand values over a valid/ready handshake.
- Decodes it into the 4-bit ALU control code and the two operands, then drives the external combinational ALU and captures result and zero flag.
- Returns the captured values over a second valid/ready handshake, flagging illegal encodings; sits between decode/regfile-read and writeback.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_decode.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 85 ++++++++
 tb/tb_alu_issue_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, RV64 opcode/funct7 constants and issue FSM states
// Ports: none (package)
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_t;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} issue_state_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV64 OP/OP-IMM decode into ALU control code and operands
// Ports: instr/rs1_val/rs2_val in; ctrl, a, b, illegal out
module alu_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output alu_op_t         ctrl,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            illegal
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [5:0] hi6;
    logic       f7_ok;
    logic [XLEN-1:0] imm, shamt;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign hi6   = instr[31:26];
    assign f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
    assign imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign shamt = {{(XLEN-6){1'b0}}, instr[25:20]};
    always_comb begin
        ctrl    = ALU_ADD;
        a       = rs1_val;
        b       = rs2_val;
        illegal = 1'b1;
        if (opc == OPC_OP) begin
            case (f3)
                3'b000:  begin ctrl = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD; illegal = !f7_ok; end
                3'b001:  begin ctrl = ALU_SLL; illegal = f7 != F7_BASE; end
                3'b100:  begin ctrl = ALU_XOR; illegal = f7 != F7_BASE; end
                3'b101:  begin ctrl = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL; illegal = !f7_ok; end
                3'b110:  begin ctrl = ALU_OR;  illegal = f7 != F7_BASE; end
                3'b111:  begin ctrl = ALU_AND; illegal = f7 != F7_BASE; end
                default: illegal = 1'b1;
            endcase
        end else if (opc == OPC_OP_IMM) begin
            b = imm;
            case (f3)
                3'b000:  begin ctrl = ALU_ADD; illegal = 1'b0; end
                3'b100:  begin ctrl = ALU_XOR; illegal = 1'b0; end
                3'b110:  begin ctrl = ALU_OR;  illegal = 1'b0; end
                3'b111:  begin ctrl = ALU_AND; illegal = 1'b0; end
                3'b001:  begin ctrl = ALU_SLL; b = shamt; illegal = hi6 != 6'b000000; end
                3'b101:  begin
                    ctrl    = (hi6 == 6'b010000) ? ALU_SRA : ALU_SRL;
                    b       = shamt;
                    illegal = !(hi6 == 6'b000000 || hi6 == 6'b010000);
                end
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded ALU instruction to an external ALU and returns its result
// Ports: in_valid/in_ready/instr/rs1_val/rs2_val request; alu_a/alu_b/alu_ctrl/alu_result/alu_zero ALU;
//        out_valid/out_ready/out_result/out_zero/out_illegal response; op_count legal ops completed
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);
    issue_state_t    state, state_n;
    alu_op_t         dec_ctrl;
    logic [XLEN-1:0] dec_a, dec_b;
    logic            dec_illegal;
    logic            accept;
    alu_decode #(.XLEN(XLEN)) u_dec (
        .instr   (instr),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .ctrl    (dec_ctrl),
        .a       (dec_a),
        .b       (dec_b),
        .illegal (dec_illegal)
    );
    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_RESP;
    assign accept    = in_valid && in_ready;
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = accept ? (dec_illegal ? S_RESP : S_EXEC) : S_IDLE;
            S_EXEC:  state_n = S_RESP;
            S_RESP:  state_n = out_ready ? S_IDLE : S_RESP;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= ALU_ADD;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            state <= state_n;
            // Illegal encodings skip EXEC, so the ALU operands keep their previous values.
            if (accept && dec_illegal) begin
                out_result  <= '0;
                out_zero    <= 1'b0;
                out_illegal <= 1'b1;
            end else if (accept) begin
                alu_a    <= dec_a;
                alu_b    <= dec_b;
                alu_ctrl <= dec_ctrl;
            end
            if (state == S_EXEC) begin
                out_result  <= alu_result;
                out_zero    <= alu_zero;
                out_illegal <= 1'b0;
                op_count    <= op_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] rs1_val = '0, rs2_val = '0;
    logic [63:0] alu_a, alu_b, alu_result, out_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, in_ready, out_valid, out_zero, out_illegal;
    logic [31:0] op_count;
    typedef struct {logic [63:0] res; logic zero; logic ill;} exp_t;
    exp_t        sb[$];
    int          checks = 0, passed = 0;
    logic [31:0] exp_cnt = '0;
    time         t_acc;

    alu_issue_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = alu_a << alu_b[5:0];
            4'd6:    alu_result = alu_a >> alu_b[5:0];
            4'd7:    alu_result = $signed(alu_a) >>> alu_b[5:0];
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = alu_result == '0;

    task automatic send(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        else passed++;
        instr = i; rs1_val = a; rs2_val = b; in_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_zero, out_illegal} !== 4'b1000)
            $display("FAIL reset_flags: in_ready,out_valid,out_zero,out_illegal=%b required 1000",
                     {in_ready, out_valid, out_zero, out_illegal});
        else passed++;
        checks++;
        if ({alu_a, alu_b, out_result} !== '0 || alu_ctrl !== 4'd0 || op_count !== 32'd0)
            $display("FAIL reset_regs: a=%h b=%h ctrl=%0d res=%h cnt=%0d required all zero",
                     alu_a, alu_b, alu_ctrl, out_result, op_count);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_legal_ops();
        logic [31:0] ins[4]  = '{32'h002081B3, 32'h402081B3, 32'hFFF00093, 32'h4040D093};
        logic [63:0] r1[4]   = '{64'd5, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0};
        logic [63:0] r2[4]   = '{64'd7, 64'h1234, 64'd0, 64'd0};
        logic [3:0]  ctl[4]  = '{4'd0, 4'd1, 4'd0, 4'd7};
        logic [63:0] bv[4]   = '{64'd7, 64'h1234, '1, 64'd4};
        logic [63:0] res[4]  = '{64'd12, 64'd0, '1, '1};
        logic        zr[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            int   cyc;
            exp_t e;
            exp_cnt++;
            sb.push_back('{res[k], zr[k], 1'b0});
            send(ins[k], r1[k], r2[k]);
            @(negedge clk);
            cyc = 1;
            checks++;
            if (alu_ctrl !== ctl[k] || alu_b !== bv[k] || alu_a !== r1[k] || out_valid !== 1'b0)
                $display("FAIL legal%0d_exec: ctrl=%0d a=%h b=%h ov=%b required ctrl=%0d a=%h b=%h ov=0",
                         k, alu_ctrl, alu_a, alu_b, out_valid, ctl[k], r1[k], bv[k]);
            else passed++;
            while (!out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != 2) $display("FAIL legal%0d_latency: %0d cycles required 2", k, cyc);
            else passed++;
            e = sb.pop_front();
            checks++;
            if (out_result !== e.res || out_zero !== e.zero || out_illegal !== e.ill || op_count !== exp_cnt)
                $display("FAIL legal%0d_resp: res=%h z=%b ill=%b cnt=%0d required res=%h z=%b ill=%b cnt=%0d",
                         k, out_result, out_zero, out_illegal, op_count, e.res, e.zero, e.ill, exp_cnt);
            else passed++;
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins[5] = '{32'h0020A1B3, 32'h00502093, 32'h0000006F, 32'h04009093, 32'h4020F1B3};
        for (int k = 0; k < 5; k++) begin
            int   cyc = 0;
            exp_t e;
            sb.push_back('{64'd0, 1'b0, 1'b1});
            send(ins[k], 64'h55, 64'h66);
            do begin
                @(negedge clk);
                cyc++;
            end while (!out_valid && cyc < 20);
            checks++;
            if (cyc != 1) $display("FAIL illegal%0d_latency: %0d cycles required 1", k, cyc);
            else passed++;
            e = sb.pop_front();
            checks++;
            if (out_result !== e.res || out_zero !== e.zero || out_illegal !== e.ill || op_count !== exp_cnt ||
                alu_ctrl !== 4'd7 || alu_b !== 64'd4)
                $display("FAIL illegal%0d_resp: res=%h z=%b ill=%b cnt=%0d ctrl=%0d b=%h required res=0 z=0 ill=1 cnt=%0d ctrl=7 b=4",
                         k, out_result, out_zero, out_illegal, op_count, alu_ctrl, alu_b, exp_cnt);
            else passed++;
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int   cyc = 0;
        exp_t e;
        exp_cnt++;
        sb.push_back('{64'd123, 1'b0, 1'b0});
        send(32'h002081B3, 64'd100, 64'd23);
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        e = sb.pop_front();
        instr = 32'h402081B3; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== e.res || out_illegal !== e.ill ||
                op_count !== exp_cnt || alu_ctrl !== 4'd0)
                $display("FAIL stall%0d: ov=%b ir=%b res=%h ill=%b cnt=%0d ctrl=%0d required ov=1 ir=0 res=%h ill=%b cnt=%0d ctrl=0",
                         k, out_valid, in_ready, out_result, out_illegal, op_count, alu_ctrl, e.res, e.ill, exp_cnt);
            else passed++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== exp_cnt)
            $display("FAIL stall_release: ir=%b ov=%b cnt=%0d required ir=1 ov=0 cnt=%0d",
                     in_ready, out_valid, op_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[5] = '{32'h0020C1B3, 32'h0F00E093, 32'h0020F1B3, 32'h03F09093, 32'h0020D1B3};
        logic [63:0] r1[5]  = '{64'hF0F0, 64'h100, 64'hFF, 64'd1, 64'h80};
        logic [63:0] r2[5]  = '{64'hFF00, 64'd0, 64'h0F, 64'd0, 64'd3};
        logic [63:0] res[5] = '{64'h0FF0, 64'h1F0, 64'h0F, 64'h8000_0000_0000_0000, 64'h10};
        time prev = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int   cyc = 0;
            exp_t e;
            exp_cnt++;
            sb.push_back('{res[k], 1'b0, 1'b0});
            send(ins[k], r1[k], r2[k]);
            if (k > 0) begin
                checks++;
                if (t_acc - prev != 30) $display("FAIL b2b%0d_rate: %0t between accepts required 30", k, t_acc - prev);
                else passed++;
            end
            prev = t_acc;
            do begin
                @(negedge clk);
                cyc++;
            end while (!out_valid && cyc < 20);
            e = sb.pop_front();
            checks++;
            if (out_result !== e.res || out_zero !== e.zero || out_illegal !== e.ill || op_count !== exp_cnt)
                $display("FAIL b2b%0d_resp: res=%h z=%b ill=%b cnt=%0d required res=%h z=%b ill=%b cnt=%0d",
                         k, out_result, out_zero, out_illegal, op_count, e.res, e.zero, e.ill, exp_cnt);
            else passed++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        send(32'h002081B3, 64'd9, 64'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== exp_cnt || out_illegal !== 1'b0 ||
            {alu_a, alu_b, out_result} !== '0 || alu_ctrl !== 4'd0)
            $display("FAIL reset_exec: ov=%b ir=%b cnt=%0d ill=%b a=%h b=%h res=%h ctrl=%0d required reset values",
                     out_valid, in_ready, op_count, out_illegal, alu_a, alu_b, out_result, alu_ctrl);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL reset_exec_idle: ov=%b pending=%0d required ov=0 pending=0", out_valid, sb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_legal_ops();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_exec();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
